// File: rtl/serial_subtractor_pkg.sv
// Shared types and defaults for the bit-serial subtractor.
package serial_subtractor_pkg;

    localparam int SS_DEF_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } ss_state_t;

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit full subtractor: diff = a - b - bin, bout is the borrow out.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic diff,
    output logic bout
);

    assign diff = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial A-B, LSB first, one bit per clock; result registered on DONE entry.
// Optional Overflow_Out port enabled by defining SERIAL_SUBTRACTOR_OVERFLOW_EN.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = SS_DEF_WIDTH
) (
    input  logic             Clock_In,
    input  logic             Reset_In,
    input  logic             Start_In,
    input  logic [WIDTH-1:0] Data_A_In,
    input  logic [WIDTH-1:0] Data_B_In,
    output logic             Busy_Out,
    output logic             Done_Out,
    output logic [WIDTH-1:0] Difference_Out,
    output logic             Borrow_Out
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
    ,
    output logic             Overflow_Out
`endif
);

    localparam int              CW      = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0]   LP_LAST = CW'(WIDTH);

    ss_state_t        r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_res;
    logic             r_bor;
    logic [CW-1:0]    r_cnt;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_diff;
    logic             r_borrow;
    logic             w_diff;
    logic             w_bout;

    full_subtractor u_fs (
        .a    (r_a[0]),
        .b    (r_b[0]),
        .bin  (r_bor),
        .diff (w_diff),
        .bout (w_bout)
    );

`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
    // Operand signs are kept aside because the operand registers shift them out.
    logic r_sa;
    logic r_sb;
    logic r_ovf;
    assign Overflow_Out = r_ovf;
`endif

    always_ff @(posedge Clock_In or posedge Reset_In) begin
        if (Reset_In) begin
            r_state  <= IDLE;
            r_a      <= '0;
            r_b      <= '0;
            r_res    <= '0;
            r_bor    <= 1'b0;
            r_cnt    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_diff   <= '0;
            r_borrow <= 1'b0;
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
            r_sa     <= 1'b0;
            r_sb     <= 1'b0;
            r_ovf    <= 1'b0;
`endif
        end else begin
            case (r_state)
                SHIFT: begin
                    if (r_cnt == LP_LAST) begin
                        r_state  <= DONE;
                        r_busy   <= 1'b0;
                        r_done   <= 1'b1;
                        r_diff   <= r_res;
                        r_borrow <= r_bor;
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
                        r_ovf    <= (r_sa != r_sb) && (r_res[WIDTH-1] != r_sa);
`endif
                    end else begin
                        r_res <= {w_diff, r_res[WIDTH-1:1]};
                        r_a   <= r_a >> 1;
                        r_b   <= r_b >> 1;
                        r_bor <= w_bout;
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    // IDLE and DONE both accept a new request; DONE falls back to IDLE.
                    r_done <= 1'b0;
                    if (Start_In) begin
                        r_state <= SHIFT;
                        r_busy  <= 1'b1;
                        r_a     <= Data_A_In;
                        r_b     <= Data_B_In;
                        r_bor   <= 1'b0;
                        r_cnt   <= '0;
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
                        r_sa    <= Data_A_In[WIDTH-1];
                        r_sb    <= Data_B_In[WIDTH-1];
`endif
                    end else begin
                        r_state <= IDLE;
                    end
                end
            endcase
        end
    end

    assign Busy_Out       = r_busy;
    assign Done_Out       = r_done;
    assign Difference_Out = r_diff;
    assign Borrow_Out     = r_borrow;

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor (WIDTH=8); covers overflow when
// SERIAL_SUBTRACTOR_OVERFLOW_EN is defined.
module tb_serial_subtractor;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] da = '0;
    logic [W-1:0] db = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         borrow;
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
    logic         ovf;
`endif

    serial_subtractor #(.WIDTH(W)) dut (
        .Clock_In       (clk),
        .Reset_In       (rst),
        .Start_In       (start),
        .Data_A_In      (da),
        .Data_B_In      (db),
        .Busy_Out       (busy),
        .Done_Out       (done),
        .Difference_Out (diff),
        .Borrow_Out     (borrow)
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
        ,
        .Overflow_Out   (ovf)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] d;
        logic         bo;
        logic         ov;
        int           at;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_bad  = 0;
    int   n_done = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h (cyc %0d)", tag, got, exp, cyc);
        end
    endtask

    // Done is expected WIDTH+1 edges after the accepting edge.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input int acc);
        exp_t e;
        e.d  = a - b;
        e.bo = (a < b);
        e.ov = (a[W-1] != b[W-1]) && (e.d[W-1] != a[W-1]);
        e.at = acc + W + 1;
        return e;
    endfunction

    always @(negedge clk) begin
        if (done) begin
            n_done++;
            if (sb.size() == 0) begin
                chk("spurious_done", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("diff", diff, e.d);
                chk("borrow", borrow, e.bo);
                chk("done_cycle", cyc, e.at);
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
                chk("overflow", ovf, e.ov);
`endif
            end
        end
    end

    // Called at posedge+#1: Start is accepted on the next edge.
    task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b);
        start = 1'b1;
        da    = a;
        db    = b;
        sb.push_back(model(a, b, cyc + 1));
        @(posedge clk); #1;
        start = 1'b0;
        da    = W'($urandom);
        db    = W'($urandom);
        chk("busy_after_start", busy, 1);
    endtask

    task automatic wait_n(input int k);
        int n0;
        int t;
        n0 = n_done;
        t  = 0;
        while ((n_done - n0) < k && t < 60) begin
            @(posedge clk);
            t++;
        end
        if ((n_done - n0) < k) chk("done_timeout", n_done - n0, k);
        #1;
    endtask

    task automatic run(input logic [W-1:0] a, input logic [W-1:0] b);
        launch(a, b);
        wait_n(1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=stuck exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_diff", diff, 0);
        chk("rst_borrow", borrow, 0);

        // Start presented on the very first edge after release.
        rst = 1'b0;
        launch(8'h35, 8'h12);
        wait_n(1);
        repeat (3) @(posedge clk);
        #1;
        chk("hold_diff", diff, 8'h23);
        chk("hold_done_low", done, 0);
        chk("idle_busy", busy, 0);

        run(8'h12, 8'h35);
        run(8'h00, 8'h01);
        run(8'h00, 8'h00);
        for (int i = 0; i < 3; i++) run(W'($urandom), W'($urandom));

        // Start during SHIFT cycle 3 must be ignored.
        n0 = n_done;
        launch(8'h50, 8'h10);
        repeat (2) @(posedge clk);
        #1;
        start = 1'b1; da = 8'hFF; db = 8'hFF;
        @(posedge clk); #1;
        start = 1'b0;
        wait_n(1);
        repeat (12) @(posedge clk);
        #1;
        chk("no_extra_done", n_done - n0, 1);

        // Start held through DONE: the DONE-cycle edge accepts the second request.
        begin
            int acc;
            acc   = cyc + 1;
            start = 1'b1; da = 8'h20; db = 8'h01;
            sb.push_back(model(8'h20, 8'h01, acc));
            sb.push_back(model(8'h09, 8'h03, acc + W + 2));
            @(posedge clk); #1;
            da = 8'h09; db = 8'h03;
            repeat (W + 1) @(posedge clk);
            #1;
            chk("b2b_first_done", done, 1);
            @(posedge clk); #1;
            start = 1'b0;
            chk("b2b_busy", busy, 1);
            wait_n(1);
            chk("b2b_diff", diff, 8'h06);
        end

        // Reset during SHIFT cycle 4 aborts the operation.
        n0 = n_done;
        launch(8'h77, 8'h22);
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_diff", diff, 0);
        chk("mid_rst_borrow", borrow, 0);
        void'(sb.pop_back());
        @(posedge clk); #1;
        rst = 1'b0;
        chk("mid_rst_no_done", n_done - n0, 0);
        launch(8'h77, 8'h22);
        wait_n(1);

`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
        run(8'h80, 8'h01);
        chk("ovf_set", ovf, 1);
        run(8'h05, 8'h03);
        chk("ovf_clear", ovf, 0);
`else
        run(8'hFF, 8'h00);
        run(8'h00, 8'hFF);
`endif

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
